// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared types and helpers for the product accumulator.
//   state_e   : window FSM states (IDLE, ACC, DONE).
//   cnt_width : width of a counter that must hold values 0..kernel_n.
package prod_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int kernel_n);
    return $clog2(kernel_n + 1);
  endfunction

endpackage

// File: rtl/prod_accumulator_acc_add_sat.sv
// acc_add_sat: combinational accumulator adder.
// The product is zero-extended and added to the accumulator in ACC_W+1 bits.
// The top bit of that sum is the carry-out.
// Optional macro PROD_ACC_SAT_EN: a carry-out clamps the sum to 2^ACC_W-1.
// A clamped accumulator re-clamps on every later non-zero term, and a zero
// term leaves it at the maximum. This keeps it saturated for the rest of the
// window without any extra state.
// Ports:
//   acc_in    [ACC_W-1:0]  current accumulator value
//   prod_in   [PROD_W-1:0] unsigned product to add
//   sum_out   [ACC_W-1:0]  wrapped (or clamped) sum
//   carry_out              carry-out of the ACC_W-bit addition
module acc_add_sat
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              carry_out
);

  logic [ACC_W:0] wide_s;

  // Widened add; the MSB is the carry, the rest is the wrapped sum.
  always_comb begin
    wide_s    = {1'b0, acc_in} + (ACC_W+1)'(prod_in);
    carry_out = wide_s[ACC_W];
`ifdef PROD_ACC_SAT_EN
    if (wide_s[ACC_W]) begin
      sum_out = {ACC_W{1'b1}};
    end else begin
      sum_out = wide_s[ACC_W-1:0];
    end
`else
    sum_out = wide_s[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums KERNEL_N consecutive unsigned products into one
// window result (a CNN kernel dot product). The result is presented on a
// registered valid/ready output together with a sticky overflow flag.
// Optional macro PROD_ACC_SAT_EN: when defined, the sum saturates instead of
// wrapping (see acc_add_sat).
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid/in_ready    input handshake; in_prod [PROD_W-1:0] is the product
//   out_valid/out_ready  output handshake; out_sum [ACC_W-1:0] and out_ovf
//   busy                 high while a window is partially accumulated
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W   = 4,
  parameter int KERNEL_N = 9,
  parameter int ACC_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = cnt_width(KERNEL_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_N - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;          // sticky flag of the open window
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;

  // In DONE the input is only accepted when the result leaves in the same cycle.
  assign in_ready  = (state_q != DONE) || out_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACC);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign prod_ext  = ACC_W'(in_prod);

  acc_add_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_in    (acc_q),
    .prod_in   (in_prod),
    .sum_out   (add_sum),
    .carry_out (add_carry)
  );

  // Next-state, accumulator, counter and result-register logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (in_xfer) begin
          // First term of a new window (from DONE this coincides with the output transfer).
          acc_d = prod_ext;
          cnt_d = CNT_ONE;
          ovf_d = 1'b0;
          if (KERNEL_N == 1) begin
            state_d   = DONE;
            out_sum_d = prod_ext;
            out_ovf_d = 1'b0;
          end else begin
            state_d = ACC;
          end
        end else if (out_xfer) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ACC: begin
        if (in_xfer) begin
          acc_d = add_sum;
          cnt_d = cnt_q + CNT_ONE;
          ovf_d = ovf_q | add_carry;
          if (cnt_q == CNT_LAST) begin
            state_d   = DONE;
            out_sum_d = add_sum;
            out_ovf_d = ovf_q | add_carry;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: a window-level model checks the default instance
// every cycle; two extra instances cover ACC_W=6 overflow and KERNEL_N=1.
module tb_prod_accumulator;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  // Instance A: defaults (PROD_W=4, KERNEL_N=9, ACC_W=8)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic [3:0] a_in_prod;
  logic [7:0] a_out_sum;
  // Instance B: ACC_W=6
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [3:0] b_in_prod;
  logic [5:0] b_out_sum;
  // Instance C: KERNEL_N=1
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf, c_busy;
  logic [3:0] c_in_prod;
  logic [7:0] c_out_sum;

  prod_accumulator #(.PROD_W(4), .KERNEL_N(9), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_prod(a_in_prod), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .busy(a_busy));

  prod_accumulator #(.PROD_W(4), .KERNEL_N(9), .ACC_W(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_prod(b_in_prod), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .busy(b_busy));

  prod_accumulator #(.PROD_W(4), .KERNEL_N(1), .ACC_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_prod(c_in_prod), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- window-level model of instance A ----------------
  int          m_win[$];     // products accepted in the open window
  logic        m_have;       // a finished result is waiting downstream
  logic [7:0]  m_sum;
  logic        m_ovf;
  int          m_total;
  logic        m_hs_in;
  logic        m_hs_out;
  int          cap_sum[$];
  int          cap_ovf[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_win.delete();
      m_have = 1'b0;
      m_sum  = 8'd0;
      m_ovf  = 1'b0;
    end else begin
      m_hs_in  = a_in_valid && (!m_have || a_out_ready);
      m_hs_out = m_have && a_out_ready;
      if (m_hs_out) m_have = 1'b0;
      if (m_hs_in) begin
        m_win.push_back(int'(a_in_prod));
        if (m_win.size() == 9) begin
          m_total = 0;
          foreach (m_win[i]) m_total = m_total + m_win[i];
          m_ovf = (m_total > 255);
`ifdef PROD_ACC_SAT_EN
          m_sum = m_ovf ? 8'd255 : m_total[7:0];
`else
          m_sum = m_total[7:0];
`endif
          m_have = 1'b1;
          m_win.delete();
        end
      end
    end
  end

  // Every-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_out_valid", 32'(a_out_valid), 32'(m_have));
      chk("a_in_ready",  32'(a_in_ready),  32'(!m_have || a_out_ready));
      chk("a_busy",      32'(a_busy),      32'(m_win.size() != 0));
      chk("a_out_sum",   32'(a_out_sum),   32'(m_sum));
      chk("a_out_ovf",   32'(a_out_ovf),   32'(m_ovf));
      if (a_out_valid && a_out_ready) begin
        cap_sum.push_back(int'(a_out_sum));
        cap_ovf.push_back(int'(a_out_ovf));
      end
    end
  end

  task automatic drv(input logic v, input logic [3:0] p, input logic r);
    @(negedge clk);
    #1;
    a_in_valid  = v;
    a_in_prod   = p;
    a_out_ready = r;
  endtask

  int exp_caps[7];
  int c_vals[3];
  int b_exp;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_prod = 4'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_prod = 4'd0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_prod = 4'd0; c_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_sum",   32'(a_out_sum),   32'd0);
    chk("rst_out_ovf",   32'(a_out_ovf),   32'd0);
    chk("rst_busy",      32'(a_busy),      32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);

    // 1) nine products of 9 -> 81
    for (int i = 0; i < 9; i++) drv(1'b1, 4'd9, 1'b1);
    drv(1'b0, 4'd0, 1'b1);
    chk("t1_valid_after_9th", 32'(a_out_valid), 32'd1);
    chk("t1_sum_literal",     32'(a_out_sum),   32'd81);
    drv(1'b0, 4'd0, 1'b1);

    // 2) products 1..9 (sum 45), then 5 cycles of backpressure with ignored inputs
    for (int i = 1; i <= 9; i++) drv(1'b1, 4'(i), 1'b1);
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 4'd15, 1'b0);
      #1;
      chk("t2_hold_sum",     32'(a_out_sum),  32'd45);
      chk("t2_hold_inready", 32'(a_in_ready), 32'd0);
    end
    drv(1'b0, 4'd0, 1'b1);
    drv(1'b0, 4'd0, 1'b0);
    chk("t2_idle_valid", 32'(a_out_valid), 32'd0);
    chk("t2_idle_busy",  32'(a_busy),      32'd0);

    // 3) reset after 4 products of 5, then nine products of 1 -> 9
    for (int i = 0; i < 4; i++) drv(1'b1, 4'd5, 1'b1);
    @(negedge clk);
    #1;
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t3_rst_sum",   32'(a_out_sum),   32'd0);
    chk("t3_rst_busy",  32'(a_busy),      32'd0);
    chk("t3_rst_valid", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) drv(1'b1, 4'd1, 1'b1);
    drv(1'b0, 4'd0, 1'b1);

    // 4) continuous windows 1,4,1,4 with the first term taken in the DONE cycle
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 9; i++) drv(1'b1, (w % 2 == 0) ? 4'd1 : 4'd4, 1'b1);
    drv(1'b0, 4'd0, 1'b1);
    drv(1'b0, 4'd0, 1'b1);

    exp_caps = '{81, 45, 9, 9, 36, 9, 36};
    chk("cap_count", 32'(cap_sum.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < cap_sum.size()) begin
        chk("cap_sum", 32'(cap_sum[i]), 32'(exp_caps[i]));
        chk("cap_ovf", 32'(cap_ovf[i]), 32'd0);
      end
    end

    // 5) ACC_W=6: nine products of 9 overflow
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      b_in_valid = 1'b1;
      b_in_prod  = 4'd9;
    end
    @(negedge clk);
    #1 b_in_valid = 1'b0;
`ifdef PROD_ACC_SAT_EN
    b_exp = 63;
`else
    b_exp = 17;
`endif
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_out_sum",   32'(b_out_sum),   32'(b_exp));
    chk("b_out_ovf",   32'(b_out_ovf),   32'd1);

    // 6) KERNEL_N=1: back-to-back 3, 7, 15
    c_vals = '{3, 7, 15};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        chk("c_out_valid", 32'(c_out_valid), 32'd1);
        chk("c_out_sum",   32'(c_out_sum),   32'(c_vals[i-1]));
        chk("c_out_ovf",   32'(c_out_ovf),   32'd0);
        chk("c_busy",      32'(c_busy),      32'd0);
      end
      if (i < 3) begin
        c_in_valid = 1'b1;
        c_in_prod  = 4'(c_vals[i]);
      end else begin
        c_in_valid = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    chk("c_idle_valid", 32'(c_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
